// File: rtl/toggle_synchronizer_alt.sv
// toggle_synchronizer_alt: carries single-cycle event strobes from clka_i to clkb_i as one-cycle pulses
//   clka_i   : source-domain clock
//   clkb_i   : destination-domain clock
//   arst_n_i : asynchronous active-low reset shared by both domains
//   data_i   : event strobe (clka_i); every clka_i cycle sampled high is one event
//   data_o   : regenerated event pulse (clkb_i), one clkb_i cycle per event
// SYNC_STAGES and RST_SYNC_STAGES are both meant to be in 2..4.
module toggle_synchronizer_alt #(
  parameter int SYNC_STAGES     = 2,
  parameter int RST_SYNC_STAGES = 2
) (
  input  logic clka_i,
  input  logic clkb_i,
  input  logic arst_n_i,
  input  logic data_i,
  output logic data_o
);
  // Each domain gets its own reset: asserted asynchronously, released on its own clock.
  logic [RST_SYNC_STAGES-1:0] rsta_q;
  logic [RST_SYNC_STAGES-1:0] rstb_q;
  logic rsta_n;
  logic rstb_n;
  logic toggle;
  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [SYNC_STAGES-1:0] sync;
  logic hist;
  always_ff @(posedge clka_i or negedge arst_n_i)
    if (!arst_n_i) rsta_q <= '0;
    else rsta_q <= {rsta_q[RST_SYNC_STAGES-2:0], 1'b1};
  always_ff @(posedge clkb_i or negedge arst_n_i)
    if (!arst_n_i) rstb_q <= '0;
    else rstb_q <= {rstb_q[RST_SYNC_STAGES-2:0], 1'b1};
  assign rsta_n = rsta_q[RST_SYNC_STAGES-1];
  assign rstb_n = rstb_q[RST_SYNC_STAGES-1];
  // The toggle flop feeds sync[0] directly so no combinational glitch can cross.
  always_ff @(posedge clka_i or negedge rsta_n)
    if (!rsta_n) toggle <= 1'b0;
    else if (data_i) toggle <= ~toggle;
  always_ff @(posedge clkb_i or negedge rstb_n)
    if (!rstb_n) begin
      sync   <= '0;
      hist   <= 1'b0;
      data_o <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], toggle};
      hist   <= sync[SYNC_STAGES-1];
      data_o <= sync[SYNC_STAGES-1] ^ hist;
    end
endmodule

// File: tb/tb_toggle_synchronizer_alt.sv
// tb_toggle_synchronizer_alt: scoreboard bench for toggle_synchronizer_alt
`timescale 1ns/100ps
module tb_toggle_synchronizer_alt;
  localparam int SYNC_STAGES = 2;
  localparam int LAT_LO = SYNC_STAGES + 1;
  localparam int LAT_HI = SYNC_STAGES + 2;
  logic clka = 1'b0;
  logic clkb = 1'b0;
  logic arst_n = 1'b0;
  logic data_i = 1'b0;
  logic data_o;
  int half_a = 1;
  int half_b = 10;
  int checks = 0;
  int failures = 0;
  int nb = 0;
  int pulses = 0;
  int loose = 0;
  int lat;
  int q[$];
  logic prev = 1'b0;
  bit mon_en = 1'b0;

  toggle_synchronizer_alt #(.SYNC_STAGES(SYNC_STAGES), .RST_SYNC_STAGES(2)) dut (
    .clka_i(clka), .clkb_i(clkb), .arst_n_i(arst_n), .data_i(data_i), .data_o(data_o)
  );

  always #(half_a) clka = ~clka;
  always #(half_b) clkb = ~clkb;
  always @(posedge clkb) nb++;

  // Scoreboard: each expected event holds the clkb edge count at the moment it was sampled.
  always @(negedge clkb) if (mon_en) begin
    if (prev === 1'b1) begin
      checks++;
      if (data_o !== 1'b0) begin
        failures++;
        $display("FAIL pulse_width data_o=%b required=0 after one high cycle at %0t", data_o, $time);
      end
    end else if (data_o === 1'b1) begin
      pulses++;
      checks++;
      if (q.size() == 0) begin
        if (loose > 0) loose--;
        else begin
          failures++;
          $display("FAIL spurious_pulse pending=0 pulses=%0d at %0t", pulses, $time);
        end
      end else begin
        lat = nb - q.pop_front();
        if (lat < LAT_LO || lat > LAT_HI) begin
          failures++;
          $display("FAIL latency got=%0d required=%0d..%0d", lat, LAT_LO, LAT_HI);
        end
      end
    end
    prev = data_o;
  end

  task automatic pulse_event(input bit expect_it);
    @(negedge clka);
    data_i = 1'b1;
    @(posedge clka);
    if (expect_it) q.push_back(nb);
    @(negedge clka);
    data_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clkb);
    repeat (3) @(posedge clkb);
  endtask

  task automatic test_reset;
    int p0;
    arst_n = 1'b0;
    repeat (3) @(posedge clkb);
    #1;
    checks++;
    if (data_o !== 1'b0) begin failures++; $display("FAIL reset_state data_o=%b required=0", data_o); end
    @(negedge clka);
    arst_n = 1'b1;
    mon_en = 1'b1;
    p0 = pulses;
    repeat (100) @(negedge clka);
    arst_n = 1'b0;
    pulse_event(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clkb);
      checks++;
      if (data_o !== 1'b0) begin failures++; $display("FAIL in_reset data_o=%b required=0", data_o); end
    end
    repeat (100) @(negedge clka);
    arst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkb);
      checks++;
      if (data_o !== 1'b0) begin failures++; $display("FAIL after_release data_o=%b required=0", data_o); end
    end
    checks++;
    if (pulses != p0) begin failures++; $display("FAIL reset_pulses got=%0d required=%0d", pulses, p0); end
  endtask

  task automatic test_single;
    int p0 = pulses;
    pulse_event(1'b1);
    wait_drain(20);
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL single_missing pending=%0d required=0", q.size()); end
    repeat (10) @(posedge clkb);
    checks++;
    if (pulses != p0 + 1) begin failures++; $display("FAIL single_count got=%0d required=%0d", pulses - p0, 1); end
  endtask

  task automatic test_back_to_back;
    int p0 = pulses;
    for (int r = 0; r < 50; r++) begin
      pulse_event(1'b1);
      repeat (50) @(negedge clka);
    end
    wait_drain(40);
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL b2b_missing pending=%0d required=0", q.size()); end
    checks++;
    if (pulses != p0 + 50) begin failures++; $display("FAIL b2b_count got=%0d required=50", pulses - p0); end
  endtask

  task automatic test_slow_to_fast;
    int p0 = pulses;
    half_a = 10;
    half_b = 1;
    repeat (4) @(posedge clka);
    for (int r = 0; r < 6; r++) begin
      pulse_event(1'b1);
      repeat (r % 3) @(negedge clka);
    end
    wait_drain(60);
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL s2f_missing pending=%0d required=0", q.size()); end
    checks++;
    if (pulses != p0 + 6) begin failures++; $display("FAIL s2f_count got=%0d required=6", pulses - p0); end
    half_a = 1;
    half_b = 10;
    repeat (4) @(posedge clkb);
  endtask

  task automatic test_reset_in_flight;
    int p0;
    pulse_event(1'b1);
    @(posedge clkb);
    #1;
    arst_n = 1'b0;
    q.delete();
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      @(negedge clkb);
      checks++;
      if (data_o !== 1'b0) begin failures++; $display("FAIL flight_reset data_o=%b required=0", data_o); end
    end
    @(negedge clka);
    arst_n = 1'b1;
    repeat (10) @(posedge clkb);
    checks++;
    if (pulses != p0) begin failures++; $display("FAIL flight_ghost got=%0d required=0", pulses - p0); end
    pulse_event(1'b1);
    wait_drain(20);
    checks++;
    if (pulses != p0 + 1 || q.size() != 0) begin
      failures++;
      $display("FAIL flight_next got=%0d pending=%0d required=1 pending 0", pulses - p0, q.size());
    end
  endtask

  task automatic test_async_assert;
    int i = 0;
    int p0;
    pulse_event(1'b1);
    while (data_o !== 1'b1 && i < 10) begin
      @(posedge clkb);
      #1;
      i++;
    end
    checks++;
    if (data_o !== 1'b1) begin failures++; $display("FAIL async_pre data_o=%b required=1", data_o); end
    arst_n = 1'b0;
    q.delete();
    p0 = pulses;
    #1;
    checks++;
    if (data_o !== 1'b0) begin failures++; $display("FAIL async_clear data_o=%b required=0", data_o); end
    repeat (3) @(posedge clkb);
    @(negedge clka);
    arst_n = 1'b1;
    repeat (10) @(posedge clkb);
    checks++;
    if (pulses != p0) begin failures++; $display("FAIL async_ghost got=%0d required=0", pulses - p0); end
  endtask

  task automatic test_merge;
    int p0 = pulses;
    loose = 1;
    pulse_event(1'b0);
    pulse_event(1'b0);
    repeat (20) @(posedge clkb);
    checks++;
    if (pulses - p0 > 1) begin failures++; $display("FAIL merge_count got=%0d required<=1", pulses - p0); end
    loose = 0;
    p0 = pulses;
    for (int r = 0; r < 3; r++) begin
      pulse_event(1'b1);
      repeat (60) @(negedge clka);
    end
    wait_drain(40);
    checks++;
    if (pulses != p0 + 3 || q.size() != 0) begin
      failures++;
      $display("FAIL merge_recover got=%0d pending=%0d required=3 pending 0", pulses - p0, q.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_slow_to_fast;
    test_reset_in_flight;
    test_async_assert;
    test_merge;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
